mfcc_melbank_coef_loader: RTL
=============================

// Module: mfcc_melbank_coef_loader
// PURPOSE
//   Run-time writer for the MFCC mel filter-bank coefficient table. Replaces the init-file-only ROM path.
//   - Accepts a framed stream of coefficient words (valid/ready) and writes them into an internal distributed RAM.
//   - Serves the same single-address read port to the mel filter stage.
//   - Lets firmware retune the filter bank without resynthesis.
// PARAMETERS
//   ADDR_WIDTH  8   table address width, range 4-10; depth = 2**ADDR_WIDTH
//   DATA_WIDTH  16  coefficient width, range 1-256
//   OUT_REG     0   0: rd_data combinational from rd_addr; 1: rd_data registered (1-cycle latency)
// PORTS
//   clk         in   1             single clock, rising edge
//   rst_n       in   1             asynchronous active-low reset
//   load_start  in   1             1-cycle pulse: begin a load; sampled only in IDLE
//   load_base   in   ADDR_WIDTH    first write address, sampled with load_start
//   load_len    in   ADDR_WIDTH+1  words to write, sampled with load_start
//   s_valid     in   1             stream word valid
//   s_ready     out  1             stream word accepted when s_valid & s_ready
//   s_data      in   DATA_WIDTH    coefficient word
//   s_last      in   1             marks the final word of the frame
//   busy        out  1             high while in LOAD or CSUM
//   done        out  1             1-cycle pulse: load finished without error
//   err         out  1             sticky error flag; cleared by the next accepted load_start
//   rd_addr     in   ADDR_WIDTH    read address
//   rd_data     out  DATA_WIDTH    read data
// BEHAVIOUR
//   Reset values: s_ready=0, busy=0, done=0, err=0, rd_data=0 when OUT_REG=1, FSM=IDLE, counters=0.
//   RAM contents are not reset; they power up as 0 and are preserved across rst_n.
//   FSM states: IDLE, LOAD, CSUM, DONE.
//     IDLE->LOAD: load_start with 1 <= load_len <= 2**ADDR_WIDTH; clears err and the word counter.
//     IDLE->DONE: load_start with load_len==0; no writes are performed.
//     IDLE (load_len > 2**ADDR_WIDTH): err=1, FSM stays in IDLE, no writes.
//     LOAD: s_ready=1. Each accepted beat k writes s_data to address (load_base+k) mod 2**ADDR_WIDTH.
//       The address wraps silently at the top of the table.
//     LOAD, beat k==load_len-1 with s_last=1: go to CSUM if the option is enabled, else DONE.
//     LOAD, s_last=1 before the final beat, or s_last=0 on the final beat: that beat is still written;
//       err=1; return to IDLE; no done pulse.
//     DONE: done=1 for exactly one cycle, then IDLE. done occurs one cycle after the final accepted beat.
//   load_start while busy: ignored; the load in progress continues.
//   s_valid outside LOAD/CSUM: ignored (s_ready=0).
//   Read port:
//     Write is synchronous; read is asynchronous from the RAM array.
//     rd_addr == write address in the same cycle: rd_data shows the old word that cycle and the new word from the next edge.
//     Reads are never blocked. During a load they return a mix of old and new coefficients,
//       so consumers must wait for done.
//   rst_n asserted mid-load: FSM returns to IDLE immediately. Words already written stay in the RAM; no done pulse.
// CONFIGURATION
//   MFCC_MELBANK_LOADER_CSUM_EN defined:
//     - After the final data beat, one extra stream beat is taken in CSUM (s_ready=1).
//     - That beat must equal the sum of all data words mod 2**DATA_WIDTH.
//     - Match: go to DONE. Mismatch: err=1, go to IDLE. The CSUM word is never written to the RAM.
//   Macro not defined: the CSUM state and the adder are absent; LOAD goes directly to DONE.
// STRUCTURE
//   Package mfcc_melbank_pkg: FSM state encoding (IDLE/LOAD/CSUM/DONE) and a DEPTH(ADDR_WIDTH) constant function.
//   Sub-module mfcc_melbank_dpram:
//     - 1 synchronous write port and 1 asynchronous read port, distributed-RAM style.
//     - Optional output register driven by OUT_REG.
//   The top level holds the FSM, the word counter, the address generator and the checksum accumulator.
// TESTING
//   1. base=0x10, len=4, words 1,2,3,4 (last on 4th) -> done 1 cycle after beat 4; rd 0x10..0x13 = 1,2,3,4; err=0.
//   2. ADDR_WIDTH=8, base=0xFE, len=4, words A,B,C,D -> rd 0xFE=A, 0xFF=B, 0x00=C, 0x01=D.
//   3. len=4, s_last on beat 2 -> err=1, no done, only 2 words written, s_ready=0 afterwards;
//      then a good load -> err clears on load_start.
//   4. len=0 -> done pulse next cycle, RAM unchanged; len=257 at ADDR_WIDTH=8 -> err=1, no writes.
//   5. load_start pulsed mid-load, and rst_n dropped after 2 of 4 beats ->
//      pulse ignored; after reset busy=0 and the first 2 words are readable.
//   6. CSUM_EN, words 0x8000,0x8001, csum 0x0001 -> done; csum 0x0002 -> err=1, no done.

Source files
------------

// File: rtl/mfcc_melbank_pkg.sv
// Shared definitions for the mel filter-bank coefficient loader:
// FSM state encoding and a table-depth helper.
package mfcc_melbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2,
        ST_DONE = 2'd3
    } mel_state_t;

    // Number of table entries for a given address width.
    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/mfcc_melbank_dpram.sv
// Coefficient table storage: one synchronous write port, one asynchronous
// read port (distributed-RAM style), with an optional output register.
// Contents are never reset so a coefficient set survives rst_n.
module mfcc_melbank_dpram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    import mfcc_melbank_pkg::*;

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_raw;

    // Synchronous write; a same-address read sees the new word from the next edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_raw = mem[rd_addr];

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_q;
            // Registered read data, one cycle behind rd_addr.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rd_q <= '0;
                else        rd_q <= rd_raw;
            end
            assign rd_data = rd_q;
        end else begin : g_comb
            logic unused_rst;
            assign unused_rst = rst_n;
            assign rd_data    = rd_raw;
        end
    endgenerate

endmodule

// File: rtl/mfcc_melbank_coef_loader.sv
// Run-time loader for the MFCC mel filter-bank coefficient table.
// Takes a framed valid/ready stream and writes it to the table at
// load_base, wrapping at the top. The mel stage reads through rd_addr.
// Optional feature macro: MFCC_MELBANK_LOADER_CSUM_EN adds a trailing
// checksum beat (sum of data words mod 2**DATA_WIDTH) checked before done.
module mfcc_melbank_coef_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    import mfcc_melbank_pkg::*;

    localparam int unsigned           DEPTH_I = depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH_I);
    localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH+1)'(1);

`ifdef MFCC_MELBANK_LOADER_CSUM_EN
    localparam mel_state_t LOAD_END = ST_CSUM;
`else
    localparam mel_state_t LOAD_END = ST_DONE;
`endif

    mel_state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  err_q;

    logic                  ld_acc;
    logic                  len_zero;
    logic                  len_bad;
    logic                  beat;
    logic                  final_beat;
    logic                  frame_bad;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign ld_acc     = (state == ST_IDLE) && load_start;
    assign len_zero   = (load_len == '0);
    assign len_bad    = (load_len > DEPTH_L);
    assign beat       = s_valid && s_ready;
    assign final_beat = (cnt_q == len_q - ONE_L);
    // s_last must coincide exactly with the final counted beat.
    assign frame_bad  = (s_last != final_beat);
    assign wr_en      = beat && (state == ST_LOAD);
    assign wr_addr    = base_q + cnt_q[ADDR_WIDTH-1:0];

`ifdef MFCC_MELBANK_LOADER_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    logic                  csum_ok;

    assign csum_ok = (s_data == csum_q);

    // Running sum of accepted data words; the checksum word itself is excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      csum_q <= '0;
        else if (ld_acc) csum_q <= '0;
        else if (wr_en)  csum_q <= csum_q + s_data;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    if (len_zero)     state_nx = ST_DONE;
                    else if (!len_bad) state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    if (frame_bad)   state_nx = ST_IDLE;
                    else if (s_last) state_nx = LOAD_END;
                end
            end
`ifdef MFCC_MELBANK_LOADER_CSUM_EN
            ST_CSUM: begin
                if (beat) state_nx = csum_ok ? ST_DONE : ST_IDLE;
            end
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        s_ready = (state == ST_LOAD) || (state == ST_CSUM);
        busy    = (state == ST_LOAD) || (state == ST_CSUM);
        done    = (state == ST_DONE);
    end

    assign err = err_q;

    // Load parameters and beat counter, captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (ld_acc) begin
            base_q <= load_base;
            len_q  <= load_len;
            cnt_q  <= '0;
        end else if (wr_en) begin
            cnt_q  <= cnt_q + ONE_L;
        end
    end

    // Sticky error: cleared by an accepted start, set on any framing fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err_q <= 1'b0;
        else if (ld_acc)           err_q <= len_bad;
        else if (wr_en && frame_bad) err_q <= 1'b1;
`ifdef MFCC_MELBANK_LOADER_CSUM_EN
        else if (beat && (state == ST_CSUM) && !csum_ok) err_q <= 1'b1;
`endif
    end

    mfcc_melbank_dpram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
